trg_seq: RTL

TRG_SEQ -- requirements
Module: trg_seq

---
 rtl/trg_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/trg_seq.sv
// Multi-stage trigger sequencer: per-stage mask/value matchers with levels, start
// stages and a strobe-counted delay; emits a one-cycle run_o pulse.
module trg_seq #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] cmd_i,
  input  logic [1:0]       stg_sel_i,
  input  logic             set_mask_i,
  input  logic             set_val_i,
  input  logic             set_cfg_i,
  input  logic             arm_i,
  input  logic             disarm_i,
  input  logic [WIDTH-1:0] smpl_i,
  input  logic             stb_i,
  output logic             run_o,
  output logic             armed_o,
  output logic [1:0]       level_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    FIRED = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [15:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] mask_q  [STAGES];
  logic [WIDTH-1:0] val_q   [STAGES];
  logic [15:0]      dly_q   [STAGES];
  logic [1:0]       lvl_q   [STAGES];
  logic             start_q [STAGES];

  logic [STAGES-1:0] hit;
  logic [STAGES-1:0] start_hit;
  logic [15:0]       win_dly;

  // Configuration is frozen once the sequencer leaves IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        mask_q[s]  <= '0;
        val_q[s]   <= '0;
        dly_q[s]   <= '0;
        lvl_q[s]   <= '0;
        start_q[s] <= 1'b0;
      end
    end else if (state_q == IDLE) begin
      if (set_mask_i) mask_q[stg_sel_i] <= cmd_i;
      if (set_val_i)  val_q[stg_sel_i]  <= cmd_i;
      if (set_cfg_i) begin
        dly_q[stg_sel_i]   <= cmd_i[15:0];
        lvl_q[stg_sel_i]   <= cmd_i[17:16];
        start_q[stg_sel_i] <= cmd_i[27];
      end
    end
  end

  always_comb begin
    hit       = '0;
    start_hit = '0;
    win_dly   = '0;
    for (int s = 0; s < STAGES; s++) begin
      hit[s] = stb_i && (lvl_q[s] == level_q) &&
               (((smpl_i ^ val_q[s]) & mask_q[s]) == '0);
      start_hit[s] = hit[s] && start_q[s];
    end
    // Descending scan so the lowest-index start stage ends up as the winner.
    for (int s = STAGES - 1; s >= 0; s--) begin
      if (start_hit[s]) win_dly = dly_q[s];
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (disarm_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_d = ARMED;
            level_d = 2'd0;
          end
        end
        ARMED: begin
          if (|start_hit) begin
            cnt_d   = win_dly;
            state_d = (win_dly == 16'd0) ? FIRED : DELAY;
          end else if ((|hit) && (level_q != 2'd3)) begin
            level_d = level_q + 2'd1;
          end
        end
        DELAY: begin
          if (stb_i) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = FIRED;
          end
        end
        FIRED: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      level_q <= 2'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run_o   = (state_q == FIRED);
  assign armed_o = (state_q == ARMED) || (state_q == DELAY);
  assign level_o = level_q;

endmodule
